// File: rtl/spi_pkg.sv
// Shared definitions for the SPI main-side transfer engine.
//   spi_main_state_e : transfer FSM states (IDLE -> SETUP -> XFER -> HOLD)
//   spi_mode_t       : latched clock mode {cpol, cpha}
//   SPI_DEFAULT_DIV  : divider value the sclk generator holds before any transfer
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_main_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int unsigned SPI_DEFAULT_DIV = 32'd4;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period counter and sclk toggle for the SPI main transfer engine.
// Every phase (SETUP, each sclk half-period, HOLD) lasts div+1 clk cycles; the
// counter reloads the latched divider at each boundary.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   load         : transfer accepted; capture div_in and park sclk at cpol_in
//   div_in       : live half-period divider
//   cpol_in      : live clock polarity (idle level while inactive)
//   cpol_lat     : polarity latched for the running transfer
//   active       : FSM is in SETUP/XFER/HOLD
//   toggle_en    : a boundary in this phase toggles sclk
//   sclk         : registered serial clock
//   bnd_stb      : one-cycle strobe, current phase ends at this edge
//   lead_stb     : boundary that moves sclk away from its idle level
//   trail_stb    : boundary that returns sclk to its idle level
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 cpol_in,
    input  logic                 cpol_lat,
    input  logic                 active,
    input  logic                 toggle_en,
    output logic                 sclk,
    output logic                 bnd_stb,
    output logic                 lead_stb,
    output logic                 trail_stb
);

    logic [DIV_WIDTH-1:0] cnt_r;
    logic [DIV_WIDTH-1:0] div_r;
    logic                 sclk_r;
    logic                 cnt_zero_s;

    assign cnt_zero_s = (cnt_r == {DIV_WIDTH{1'b0}});
    assign bnd_stb    = active && cnt_zero_s;
    // Edge kind is decided by where sclk is now: leaving idle level is leading.
    assign lead_stb   = bnd_stb && toggle_en && (sclk_r == cpol_lat);
    assign trail_stb  = bnd_stb && toggle_en && (sclk_r != cpol_lat);
    assign sclk       = sclk_r;

    // Half-period counter, divider capture and sclk level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {DIV_WIDTH{1'b0}};
            div_r  <= DIV_WIDTH'(SPI_DEFAULT_DIV);
            sclk_r <= 1'b0;
        end else if (load) begin
            cnt_r  <= div_in;
            div_r  <= div_in;
            sclk_r <= cpol_in;
        end else if (active) begin
            if (cnt_zero_s) begin
                cnt_r <= div_r;
                if (toggle_en) begin
                    sclk_r <= ~sclk_r;
                end else begin
                    sclk_r <= sclk_r;
                end
            end else begin
                cnt_r <= cnt_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            // Idle: sclk tracks the live polarity one cycle late.
            sclk_r <= cpol_in;
        end
    end

endmodule

// File: rtl/spi_main_xfer.sv
// SPI main-side (controller) transfer engine: one DATA_WIDTH word per start,
// all four CPOL/CPHA modes, sclk half-period of clk_div+1 pclk cycles.
// Optional feature: define SPI_MAIN_LSB_FIRST_EN to add the lsb_first input,
// latched with start, selecting LSB-first shifting of tx and assembly of rx.
// Ports:
//   pclk, presetn : clock, async active-low reset
//   start         : request a transfer (accepted only when idle and not on done)
//   tx_data, cpol, cpha, clk_div (, lsb_first) : latched when start is accepted
//   miso_pad_i    : serial data from sub
//   sclk_pad_o, ss_n_pad_o, mosi_pad_o : registered pad outputs
//   rx_data       : last received word, updated only on the done cycle
//   busy          : high for the whole transfer
//   done          : one-cycle completion pulse
module spi_main_xfer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
`ifdef SPI_MAIN_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    input  logic                  miso_pad_i,
    output logic                  sclk_pad_o,
    output logic                  ss_n_pad_o,
    output logic                  mosi_pad_o,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done
);

    localparam int              HP_W    = $clog2(2 * DATA_WIDTH);
    localparam logic [HP_W-1:0] LAST_HP = HP_W'(2 * DATA_WIDTH - 1);

    spi_main_state_e       state_r;
    spi_mode_t             mode_r;
    logic                  lsb_r;
    logic [DATA_WIDTH-1:0] tx_sh_r;
    logic [DATA_WIDTH-1:0] rx_sh_r;
    logic [HP_W-1:0]       hp_cnt_r;

    logic accept_s;
    logic active_s;
    logic toggle_en_s;
    logic bnd_s;
    logic lead_s;
    logic trail_s;
    logic lsb_in_s;

`ifdef SPI_MAIN_LSB_FIRST_EN
    assign lsb_in_s = lsb_first;
`else
    assign lsb_in_s = 1'b0;
`endif

    // Next bit to put on the wire from a shift word.
    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        if (lsb) begin
            head_bit = w[0];
        end else begin
            head_bit = w[DATA_WIDTH-1];
        end
    endfunction

    // Shift word with its head bit consumed.
    function automatic logic [DATA_WIDTH-1:0] drop_head(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        if (lsb) begin
            drop_head = {1'b0, w[DATA_WIDTH-1:1]};
        end else begin
            drop_head = {w[DATA_WIDTH-2:0], 1'b0};
        end
    endfunction

    // Receive word with a newly sampled bit appended in wire order.
    function automatic logic [DATA_WIDTH-1:0] push_bit(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b, input logic lsb);
        if (lsb) begin
            push_bit = {b, w[DATA_WIDTH-1:1]};
        end else begin
            push_bit = {w[DATA_WIDTH-2:0], b};
        end
    endfunction

    // The done cycle is already IDLE, so it is excluded explicitly to forbid back-to-back starts.
    assign accept_s    = (state_r == IDLE) && start && !done;
    assign active_s    = (state_r != IDLE);
    // The last XFER half-period already sits at the idle level, so its end does not toggle.
    assign toggle_en_s = (state_r == SETUP) || ((state_r == XFER) && (hp_cnt_r != LAST_HP));

    spi_sclk_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sclk_gen (
        .clk       (pclk),
        .rst_n     (presetn),
        .load      (accept_s),
        .div_in    (clk_div),
        .cpol_in   (cpol),
        .cpol_lat  (mode_r.cpol),
        .active    (active_s),
        .toggle_en (toggle_en_s),
        .sclk      (sclk_pad_o),
        .bnd_stb   (bnd_s),
        .lead_stb  (lead_s),
        .trail_stb (trail_s)
    );

    // Transfer FSM with shift registers and registered pad/status outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r    <= IDLE;
            mode_r     <= '{cpol: 1'b0, cpha: 1'b0};
            lsb_r      <= 1'b0;
            tx_sh_r    <= {DATA_WIDTH{1'b0}};
            rx_sh_r    <= {DATA_WIDTH{1'b0}};
            hp_cnt_r   <= {HP_W{1'b0}};
            ss_n_pad_o <= 1'b1;
            mosi_pad_o <= 1'b0;
            rx_data    <= {DATA_WIDTH{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            // cpha=0: sample on leading, shift on trailing; cpha=1: the reverse.
            if (lead_s) begin
                if (mode_r.cpha) begin
                    mosi_pad_o <= head_bit(tx_sh_r, lsb_r);
                    tx_sh_r    <= drop_head(tx_sh_r, lsb_r);
                end else begin
                    rx_sh_r <= push_bit(rx_sh_r, miso_pad_i, lsb_r);
                end
            end else if (trail_s) begin
                if (mode_r.cpha) begin
                    rx_sh_r <= push_bit(rx_sh_r, miso_pad_i, lsb_r);
                end else begin
                    mosi_pad_o <= head_bit(tx_sh_r, lsb_r);
                    tx_sh_r    <= drop_head(tx_sh_r, lsb_r);
                end
            end

            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r    <= SETUP;
                        mode_r     <= '{cpol: cpol, cpha: cpha};
                        lsb_r      <= lsb_in_s;
                        rx_sh_r    <= {DATA_WIDTH{1'b0}};
                        hp_cnt_r   <= {HP_W{1'b0}};
                        ss_n_pad_o <= 1'b0;
                        busy       <= 1'b1;
                        // cpha=0 needs the first bit valid before the first leading edge.
                        if (!cpha) begin
                            mosi_pad_o <= head_bit(tx_data, lsb_in_s);
                            tx_sh_r    <= drop_head(tx_data, lsb_in_s);
                        end else begin
                            mosi_pad_o <= 1'b0;
                            tx_sh_r    <= tx_data;
                        end
                    end
                end
                SETUP: begin
                    if (bnd_s) begin
                        state_r <= XFER;
                    end
                end
                XFER: begin
                    if (bnd_s) begin
                        if (hp_cnt_r == LAST_HP) begin
                            state_r <= HOLD;
                        end else begin
                            hp_cnt_r <= hp_cnt_r + {{(HP_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                HOLD: begin
                    if (bnd_s) begin
                        state_r    <= IDLE;
                        ss_n_pad_o <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        mosi_pad_o <= 1'b0;
                        rx_data    <= rx_sh_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_main_xfer.sv
// Randomized scoreboard bench for spi_main_xfer with a behavioural SPI sub model.
module tb_spi_main_xfer;

    localparam int DW   = 8;
    localparam int DIVW = 8;
`ifdef SPI_MAIN_LSB_FIRST_EN
    localparam bit LSB_EN = 1'b1;
`else
    localparam bit LSB_EN = 1'b0;
`endif

    logic            pclk = 1'b0;
    logic            presetn = 1'b1;
    logic            start = 1'b0;
    logic [DW-1:0]   tx_data = '0;
    logic            cpol = 1'b0;
    logic            cpha = 1'b0;
    logic [DIVW-1:0] clk_div = '0;
`ifdef SPI_MAIN_LSB_FIRST_EN
    logic            lsb_first = 1'b0;
`endif
    logic            miso_pad_i = 1'b0;
    logic            sclk_pad_o, ss_n_pad_o, mosi_pad_o, busy, done;
    logic [DW-1:0]   rx_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] tx;
        int            t0;
        int            lat;
    } exp_t;
    exp_t exp_q[$];

    // Sub model configuration (written by stimulus while idle) and observations.
    logic [DW-1:0] s_word = '0;
    logic          s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    int            s_h = 1;
    logic [DW-1:0] s_cap = '0;
    int            s_samp = 0, s_tx_idx = 0, s_tog = 0, s_last_tog = 0;
    logic          s_spacing_ok = 1'b1, s_idle_ok = 1'b1;
    logic          prev_ss = 1'b1, prev_sclk = 1'b0;
    logic          busy_ok = 1'b1;

    spi_main_xfer #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .start      (start),
        .tx_data    (tx_data),
        .cpol       (cpol),
        .cpha       (cpha),
        .clk_div    (clk_div),
`ifdef SPI_MAIN_LSB_FIRST_EN
        .lsb_first  (lsb_first),
`endif
        .miso_pad_i (miso_pad_i),
        .sclk_pad_o (sclk_pad_o),
        .ss_n_pad_o (ss_n_pad_o),
        .mosi_pad_o (mosi_pad_o),
        .rx_data    (rx_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic sbit(input logic [DW-1:0] w, input int i, input logic l);
        return l ? w[i] : w[DW-1-i];
    endfunction

    // SPI sub: drives miso on its shift edges, captures mosi on its sample edges.
    always @(negedge pclk) begin
        if (!presetn) begin
            prev_ss   = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (prev_ss && !ss_n_pad_o) begin
                s_tx_idx = 0; s_cap = '0; s_samp = 0; s_tog = 0;
                s_spacing_ok = 1'b1; s_last_tog = cyc;
                s_idle_ok = (sclk_pad_o == s_cpol);
                if (!s_cpha) begin
                    miso_pad_i = sbit(s_word, 0, s_lsb);
                    s_tx_idx = 1;
                end
            end else if (!ss_n_pad_o && (sclk_pad_o != prev_sclk)) begin
                s_tog++;
                if (cyc - s_last_tog != s_h) s_spacing_ok = 1'b0;
                s_last_tog = cyc;
                // leading edge = leaving idle level; sampling edge is leading iff cpha=0
                if ((sclk_pad_o != s_cpol) == !s_cpha) begin
                    if (s_samp < DW) begin
                        if (s_lsb) s_cap[s_samp] = mosi_pad_o;
                        else       s_cap[DW-1-s_samp] = mosi_pad_o;
                    end
                    s_samp++;
                end else if (s_tx_idx < DW) begin
                    miso_pad_i = sbit(s_word, s_tx_idx, s_lsb);
                    s_tx_idx++;
                end
            end
            prev_ss   = ss_n_pad_o;
            prev_sclk = sclk_pad_o;
        end
    end

    // Monitor: busy window check and scoreboard pop on every done pulse.
    always @(negedge pclk) begin : mon
        exp_t e;
        if (presetn) begin
            if (exp_q.size() > 0 && cyc >= exp_q[0].t0 + 1 && cyc < exp_q[0].t0 + exp_q[0].lat)
                if (!busy || ss_n_pad_o || done) busy_ok = 1'b0;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL done_unexpected: got done=1, want no done (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.rx));
                    chk("done_cycle", 32'(cyc - e.t0), 32'(e.lat));
                    chk("mosi_word", 32'(s_cap), 32'(e.tx));
                    chk("sample_edges", 32'(s_samp), 32'(DW));
                    chk("sclk_toggles", 32'(s_tog), 32'(2 * DW));
                    chk("half_period", 32'(s_spacing_ok), 32'd1);
                    chk("sclk_idle_cpol", 32'(s_idle_ok), 32'd1);
                    chk("busy_window", 32'(busy_ok), 32'd1);
                    chk("end_pads", 32'({ss_n_pad_o, busy, mosi_pad_o}), 32'b100);
                    busy_ok = 1'b1;
                end
            end
        end
    end

    task automatic do_xfer(input logic p_cpol, input logic p_cpha, input logic [DIVW-1:0] p_div,
                           input logic [DW-1:0] p_tx, input logic [DW-1:0] p_sw,
                           input logic p_lsb, input bit poke);
        exp_t e;
        int   k;
        @(negedge pclk);
        cpol = p_cpol; cpha = p_cpha; clk_div = p_div; tx_data = p_tx;
`ifdef SPI_MAIN_LSB_FIRST_EN
        lsb_first = p_lsb;
`endif
        s_cpol = p_cpol; s_cpha = p_cpha; s_lsb = p_lsb; s_word = p_sw; s_h = int'(p_div) + 1;
        repeat (2) @(negedge pclk);
        e.rx = p_sw; e.tx = p_tx; e.t0 = cyc; e.lat = 1 + s_h * (2 * DW + 2);
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        // live inputs change mid-transfer; only latched copies may matter
        tx_data = DW'($urandom); cpha = ~p_cpha; cpol = 1'($urandom); clk_div = DIVW'($urandom);
`ifdef SPI_MAIN_LSB_FIRST_EN
        lsb_first = ~p_lsb;
`endif
        if (poke) begin
            repeat (4) @(negedge pclk);
            start = 1'b1;
            @(negedge pclk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < e.lat + 20) begin
            @(negedge pclk);
            k++;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done in %0d cycles, want done", k);
        end else begin
            if (poke) start = 1'b1;
            @(negedge pclk);
            start = 1'b0;
            chk("start_on_done_ignored", 32'({busy, ss_n_pad_o}), 32'b01);
        end
    endtask

    task automatic reset_mid();
        exp_t e;
        @(negedge pclk);
        cpol = 1'b1; cpha = 1'b0; clk_div = 8'd2; tx_data = 8'h5A;
        s_cpol = 1'b1; s_cpha = 1'b0; s_lsb = 1'b0; s_word = 8'hC3; s_h = 3;
        repeat (2) @(negedge pclk);
        e.rx = 8'hC3; e.tx = 8'h5A; e.t0 = cyc; e.lat = 1 + 3 * (2 * DW + 2);
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        // bit 4 leading edge begins half-period 8, i.e. 9 phases after SETUP start
        repeat (3 * 9 + 1) @(negedge pclk);
        chk("busy_before_abort", 32'(busy), 32'd1);
        presetn = 1'b0;
        #1;
        chk("abort_ss_n", 32'(ss_n_pad_o), 32'd1);
        chk("abort_sclk", 32'(sclk_pad_o), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rx_data", 32'(rx_data), 32'h00);
        exp_q.delete();
        busy_ok = 1'b1;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        repeat (80) @(negedge pclk);
        chk("idle_after_abort", 32'({busy, ss_n_pad_o}), 32'b01);
    endtask

    initial begin
        #2 presetn = 1'b0;
        #1;
        chk("rst_sclk", 32'(sclk_pad_o), 32'd0);
        chk("rst_ss_n", 32'(ss_n_pad_o), 32'd1);
        chk("rst_mosi", 32'(mosi_pad_o), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge pclk);
        presetn = 1'b1;

        do_xfer(1'b0, 1'b0, 8'd1, 8'hA5, 8'h3C, 1'b0, 1'b0);
        do_xfer(1'b0, 1'b1, 8'd0, 8'h81, 8'h7E, 1'b0, 1'b1);
        do_xfer(1'b1, 1'b0, 8'd0, 8'h81, 8'h7E, 1'b0, 1'b1);
        do_xfer(1'b1, 1'b1, 8'd0, 8'h81, 8'h7E, 1'b0, 1'b0);
        do_xfer(1'b0, 1'b0, 8'd0, 8'h3F, 8'h00, 1'b0, 1'b0);
        reset_mid();
`ifdef SPI_MAIN_LSB_FIRST_EN
        do_xfer(1'b0, 1'b0, 8'd1, 8'h01, 8'h80, 1'b1, 1'b0);
`endif
        for (int i = 0; i < 30; i++) begin
            do_xfer(1'($urandom), 1'($urandom), DIVW'($urandom_range(0, 3)),
                    DW'($urandom), DW'($urandom), LSB_EN & 1'($urandom), 1'($urandom));
        end
        do_xfer(1'b0, 1'b0, 8'd255, 8'hFF, 8'h5A, 1'b0, 1'b0);

        repeat (5) @(negedge pclk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1);
    end

endmodule
